// File: rtl/ahb_slave_if_param.sv
// ---------------------------------------------------------------------------
// ahb_slave_if_param
//
// AHB-side front end of the AHB-to-APB bridge. It qualifies AHB transfers,
// decodes HADDR into NUM_SLV one-hot APB selects and pipelines
// address/data/direction PIPE_DEPTH deep. The pipeline holds while
// hready_in is low. Read data from the bridge FSM is passed straight back to
// the AHB master.
//
// Optional feature macro: AHB_SLV_ERR_RESP_EN
//   defined   : an out-of-window active transfer gets a two-cycle AHB ERROR
//               response from a small error FSM.
//   undefined : no FSM is built. hresp is tied 0 and hready_out = apb_ready.
//               Out-of-window transfers are silently ignored.
//
// Ports
//   hclk, hresetn     clock, asynchronous active-low reset
//   hwrite, hready_in, htrans, haddr, hwdata   AHB request side
//   pr_data           APB read data from the bridge FSM
//   apb_ready         bridge FSM ready (low inserts AHB wait states)
//   valid             qualified transfer into the bridge window this cycle
//   temp_sel          combinational one-hot slave select for the current haddr
//   sel_reg           temp_sel registered alongside pipeline stage 0
//   haddr_p/hwdata_p  packed pipeline stages, stage k at [k*W +: W], k=0 newest
//   hwrite_p          direction pipeline, stage k at bit k
//   hr_data           read data to the AHB master (= pr_data)
//   hready_out        AHB HREADYOUT
//   hresp             AHB HRESP (1 = ERROR)
//   err_state_dbg     current error FSM state (0 when the FSM is not built)
//
// Handshake: an AHB address phase is accepted on a rising hclk edge where
// hready_in is 1. Only then does the pipeline advance and the error FSM see
// the transfer. hready_out low tells the interconnect that the current data
// phase is not complete (the bridge is busy or the first error cycle is in
// progress).
// ---------------------------------------------------------------------------
module ahb_slave_if_param #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                SLV_SZ_LOG2 = 26,
  parameter int                PIPE_DEPTH  = 2
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hwrite,
  input  logic                         hready_in,
  input  logic [1:0]                   htrans,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic [DATA_W-1:0]            pr_data,
  input  logic                         apb_ready,
  output logic                         valid,
  output logic [NUM_SLV-1:0]           temp_sel,
  output logic [NUM_SLV-1:0]           sel_reg,
  output logic [PIPE_DEPTH*ADDR_W-1:0] haddr_p,
  output logic [PIPE_DEPTH*DATA_W-1:0] hwdata_p,
  output logic [PIPE_DEPTH-1:0]        hwrite_p,
  output logic [DATA_W-1:0]            hr_data,
  output logic                         hready_out,
  output logic                         hresp,
  output logic [1:0]                   err_state_dbg
);

  // The window bounds use one extra bit so that a window that ends exactly at
  // the top of the address space cannot wrap around to zero.
  localparam logic [ADDR_W:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_SPAN = (ADDR_W+1)'(NUM_SLV) << SLV_SZ_LOG2;
  localparam logic [ADDR_W:0] WIN_HI   = WIN_LO + WIN_SPAN;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR1     = 2'd1,
    ERR2     = 2'd2
  } err_state_e;

  // -------------------------------------------------------------------------
  // Transfer qualification and address decode
  // -------------------------------------------------------------------------
  logic              active;
  logic              in_win;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] slot;

  always_comb begin
    // NONSEQ (2'b10) and SEQ (2'b11) are the only types with bit 1 set.
    active   = htrans[1];
    addr_ext = {1'b0, haddr};
    in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    offset   = haddr - BASE_ADDR;
    slot     = offset >> SLV_SZ_LOG2;
    valid    = hready_in & active & in_win;
    temp_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      temp_sel[i] = in_win && (slot == ADDR_W'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Address / data / direction pipeline
  // -------------------------------------------------------------------------
  logic [PIPE_DEPTH*ADDR_W-1:0] haddr_p_q,  haddr_p_d;
  logic [PIPE_DEPTH*DATA_W-1:0] hwdata_p_q, hwdata_p_d;
  logic [PIPE_DEPTH-1:0]        hwrite_p_q, hwrite_p_d;
  logic [NUM_SLV-1:0]           sel_reg_q,  sel_reg_d;

  always_comb begin
    haddr_p_d  = haddr_p_q;
    hwdata_p_d = hwdata_p_q;
    hwrite_p_d = hwrite_p_q;
    sel_reg_d  = sel_reg_q;
    if (hready_in) begin
      // Shift every stage one slot older, then put the new request in
      // stage 0. This form also works for a depth of one.
      haddr_p_d              = haddr_p_q << ADDR_W;
      haddr_p_d[ADDR_W-1:0]  = haddr;
      hwdata_p_d             = hwdata_p_q << DATA_W;
      hwdata_p_d[DATA_W-1:0] = hwdata;
      hwrite_p_d             = hwrite_p_q << 1;
      hwrite_p_d[0]          = hwrite;
      sel_reg_d              = temp_sel;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_p_q  <= '0;
      hwdata_p_q <= '0;
      hwrite_p_q <= '0;
      sel_reg_q  <= '0;
    end else begin
      haddr_p_q  <= haddr_p_d;
      hwdata_p_q <= hwdata_p_d;
      hwrite_p_q <= hwrite_p_d;
      sel_reg_q  <= sel_reg_d;
    end
  end

  assign haddr_p  = haddr_p_q;
  assign hwdata_p = hwdata_p_q;
  assign hwrite_p = hwrite_p_q;
  assign sel_reg  = sel_reg_q;
  assign hr_data  = pr_data;

  // -------------------------------------------------------------------------
  // AHB response
  // -------------------------------------------------------------------------
`ifdef AHB_SLV_ERR_RESP_EN
  err_state_e err_state_q, err_state_d;
  logic       bad_xfer;

  always_comb begin
    bad_xfer    = hready_in & active & ~in_win;
    err_state_d = err_state_q;
    hresp       = 1'b0;
    unique case (err_state_q)
      ERR_IDLE: begin
        if (bad_xfer) err_state_d = ERR1;
      end
      ERR1: begin
        hresp       = 1'b1;
        err_state_d = ERR2;
      end
      ERR2: begin
        // The second error cycle only completes once the bridge is ready.
        // A new bad transfer in that cycle restarts the response.
        hresp = 1'b1;
        if (apb_ready) err_state_d = bad_xfer ? ERR1 : ERR_IDLE;
      end
      default: err_state_d = ERR_IDLE;
    endcase
    hready_out = apb_ready & (err_state_q != ERR1);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) err_state_q <= ERR_IDLE;
    else          err_state_q <= err_state_d;
  end

  assign err_state_dbg = err_state_q;
`else
  always_comb begin
    hresp      = 1'b0;
    hready_out = apb_ready;
  end

  assign err_state_dbg = ERR_IDLE;
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
module tb_ahb_slave_if_param;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          NSLV   = 3;
  localparam int          PD     = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          SZL    = 26;
`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 hclk, hresetn;
  logic                 hwrite, hready_in, apb_ready;
  logic [1:0]           htrans;
  logic [ADDR_W-1:0]    haddr;
  logic [DATA_W-1:0]    hwdata, pr_data;
  logic                 valid, hready_out, hresp;
  logic [NSLV-1:0]      temp_sel, sel_reg;
  logic [PD*ADDR_W-1:0] haddr_p;
  logic [PD*DATA_W-1:0] hwdata_p;
  logic [PD-1:0]        hwrite_p;
  logic [DATA_W-1:0]    hr_data;
  logic [1:0]           err_state_dbg;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  ahb_slave_if_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NSLV), .BASE_ADDR(BASE),
    .SLV_SZ_LOG2(SZL), .PIPE_DEPTH(PD)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .pr_data(pr_data),
    .apb_ready(apb_ready), .valid(valid), .temp_sel(temp_sel), .sel_reg(sel_reg),
    .haddr_p(haddr_p), .hwdata_p(hwdata_p), .hwrite_p(hwrite_p), .hr_data(hr_data),
    .hready_out(hready_out), .hresp(hresp), .err_state_dbg(err_state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Pipeline is a plain array of stages; error response is tracked as a
  // count of remaining error cycles.
  logic [ADDR_W-1:0] m_addr [PD];
  logic [DATA_W-1:0] m_data [PD];
  logic              m_wr   [PD];
  logic [NSLV-1:0]   m_sel;
  int                m_phase;   // 0 = none, 1 = first error cycle, 2 = second

  function automatic bit ref_in_win(logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = a;
    lo = BASE;
    hi = lo + NSLV * (64'd1 << SZL);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [NSLV-1:0] ref_sel(logic [31:0] a);
    longint unsigned idx;
    logic [NSLV-1:0] s;
    s = '0;
    if (ref_in_win(a)) begin
      idx = (longint'(a) - longint'(BASE)) / (64'd1 << SZL);
      s[idx] = 1'b1;
    end
    return s;
  endfunction

  function automatic bit ref_active(logic [1:0] t);
    return (t == 2'b10) || (t == 2'b11);
  endfunction

  function automatic bit ref_valid(bit rdy, logic [1:0] t, logic [31:0] a);
    return rdy && ref_active(t) && ref_in_win(a);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < PD; k++) begin
      m_addr[k] = '0; m_data[k] = '0; m_wr[k] = 1'b0;
    end
    m_sel   = '0;
    m_phase = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(logic [1:0] t, logic [31:0] a, logic [31:0] d, logic w, logic rdy);
    @(negedge hclk);
    htrans = t; haddr = a; hwdata = d; hwrite = w; hready_in = rdy;
    pr_data = $urandom;
    #1;
  endtask

  // One rising edge; the model advances on what the DUT saw at that edge.
  task automatic tick();
    bit bad;
    @(posedge hclk);
    bad = hready_in && ref_active(htrans) && !ref_in_win(haddr);
    if (!hresetn) begin
      model_clear();
    end else begin
      if (hready_in) begin
        for (int k = PD - 1; k > 0; k--) begin
          m_addr[k] = m_addr[k-1]; m_data[k] = m_data[k-1]; m_wr[k] = m_wr[k-1];
        end
        m_addr[0] = haddr; m_data[0] = hwdata; m_wr[0] = hwrite;
        m_sel     = ref_sel(haddr);
      end
      if (ERR_EN) begin
        if (m_phase == 1)                 m_phase = 2;
        else if (m_phase == 2 && apb_ready) m_phase = bad ? 1 : 0;
        else if (m_phase == 0 && bad)     m_phase = 1;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hresetn = 1'b0; apb_ready = 1'b1; hready_in = 1'b1; htrans = 2'b00;
    haddr = '0; hwdata = '0; hwrite = 1'b0; pr_data = '0;
    model_clear();
    #3;
    n_tests++;
    if (haddr_p !== '0 || hwdata_p !== '0 || hwrite_p !== '0 || sel_reg !== '0) begin
      n_fail++;
      $display("FAIL reset_pipe: haddr_p=%h hwdata_p=%h hwrite_p=%b sel_reg=%b required all 0",
               haddr_p, hwdata_p, hwrite_p, sel_reg);
    end
    n_tests++;
    if (hready_out !== 1'b1 || hresp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: hready_out=%b hresp=%b required 1/0", hready_out, hresp);
    end
    @(negedge hclk); hresetn = 1'b1;
    // Fill the pipeline, then reset asynchronously mid-burst.
    drive(2'b10, 32'h8000_1000, 32'hAAAA_0001, 1'b1, 1'b1); tick();
    drive(2'b11, 32'h8000_1004, 32'hAAAA_0002, 1'b1, 1'b1); tick();
    drive(2'b11, 32'h8000_1008, 32'hAAAA_0003, 1'b1, 1'b1);
    #2; hresetn = 1'b0; #1;
    n_tests++;
    if (haddr_p !== '0 || hwdata_p !== '0 || hwrite_p !== '0 || sel_reg !== '0) begin
      n_fail++;
      $display("FAIL reset_midburst: haddr_p=%h hwdata_p=%h hwrite_p=%b sel_reg=%b required all 0",
               haddr_p, hwdata_p, hwrite_p, sel_reg);
    end
    n_tests++;
    if (hready_out !== 1'b1 || hresp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midburst_resp: hready_out=%b hresp=%b required 1/0", hready_out, hresp);
    end
    model_clear();
    @(negedge hclk); hresetn = 1'b1; htrans = 2'b00;
  endtask

  task automatic test_basic_write();
    drive(2'b10, 32'h8400_0010, 32'h1234_5678, 1'b1, 1'b1);
    n_tests++;
    if (valid !== 1'b1 || temp_sel !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_comb: valid=%b temp_sel=%b required 1/010", valid, temp_sel);
    end
    tick();
    n_tests++;
    if (haddr_p[31:0] !== 32'h8400_0010 || hwrite_p[0] !== 1'b1 ||
        hwdata_p[31:0] !== 32'h1234_5678 || sel_reg !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_stage0: addr=%h wr=%b data=%h sel_reg=%b required 84000010/1/12345678/010",
               haddr_p[31:0], hwrite_p[0], hwdata_p[31:0], sel_reg);
    end
    drive(2'b00, 32'h0000_0000, 32'h0, 1'b0, 1'b1);
    tick();
    n_tests++;
    if (haddr_p[63:32] !== 32'h8400_0010 || hwrite_p[1] !== 1'b1 || hwdata_p[63:32] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL basic_stage1: addr=%h wr=%b data=%h required 84000010/1/12345678",
               haddr_p[63:32], hwrite_p[1], hwdata_p[63:32]);
    end
  endtask

  task automatic test_stall();
    drive(2'b10, 32'h8000_0100, 32'h0000_00A1, 1'b1, 1'b1); tick();
    drive(2'b10, 32'h8800_0200, 32'h0000_00A2, 1'b0, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, 32'h8000_0000 + 32'(c * 16), $urandom, c[0], 1'b0);
      tick();
      n_tests++;
      if (haddr_p !== {32'h8000_0100, 32'h8800_0200} ||
          hwdata_p !== {32'h0000_00A1, 32'h0000_00A2} || hwrite_p !== 2'b10 || sel_reg !== 3'b100) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: haddr_p=%h hwdata_p=%h hwrite_p=%b sel_reg=%b required 8000010088000200/000000a1000000a2/10/100",
                 c, haddr_p, hwdata_p, hwrite_p, sel_reg);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [4];
    logic [2:0]  sels  [4];
    logic        vals  [4];
    addrs[0] = 32'h8BFF_FFFC; sels[0] = 3'b100; vals[0] = 1'b1;
    addrs[1] = 32'h8C00_0000; sels[1] = 3'b000; vals[1] = 1'b0;
    addrs[2] = 32'h7FFF_FFFC; sels[2] = 3'b000; vals[2] = 1'b0;
    addrs[3] = 32'h8000_0000; sels[3] = 3'b001; vals[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      htrans = 2'b10; haddr = addrs[i]; hready_in = 1'b0; #1;
      n_tests++;
      if (temp_sel !== sels[i] || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary_stalled %h: temp_sel=%b valid=%b required %b/0",
                 addrs[i], temp_sel, valid, sels[i]);
      end
      hready_in = 1'b1; #1;
      n_tests++;
      if (temp_sel !== sels[i] || valid !== vals[i]) begin
        n_fail++;
        $display("FAIL boundary %h: temp_sel=%b valid=%b required %b/%b",
                 addrs[i], temp_sel, valid, sels[i], vals[i]);
      end
    end
    htrans = 2'b00;
  endtask

  task automatic test_seq_outside();
    drive(2'b11, 32'h9000_0000, 32'h0, 1'b0, 1'b1);
    n_tests++;
    if (valid !== 1'b0 || temp_sel !== 3'b000) begin
      n_fail++;
      $display("FAIL seq_outside: valid=%b temp_sel=%b required 0/000", valid, temp_sel);
    end
    drive(2'b01, 32'h8000_0040, 32'h0, 1'b0, 1'b1);
    n_tests++;
    if (valid !== 1'b0 || temp_sel !== 3'b001) begin
      n_fail++;
      $display("FAIL busy_in_window: valid=%b temp_sel=%b required 0/001", valid, temp_sel);
    end
    // Let any error response from the SEQ transfer drain.
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_error_resp();
    bit e_hresp, e_rdy;
    drive(2'b10, 32'h9000_0000, 32'h0, 1'b1, 1'b1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL err_valid: valid=%b required 0", valid);
    end
    tick();
    e_hresp = ERR_EN; e_rdy = !ERR_EN;
    n_tests++;
    if (hresp !== e_hresp || hready_out !== e_rdy) begin
      n_fail++;
      $display("FAIL err_cycle1: hresp=%b hready_out=%b required %b/%b", hresp, hready_out, e_hresp, e_rdy);
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    n_tests++;
    if (hresp !== e_hresp || hready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cycle2: hresp=%b hready_out=%b required %b/1", hresp, hready_out, e_hresp);
    end
    tick();
    n_tests++;
    if (hresp !== 1'b0 || hready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cycle3: hresp=%b hready_out=%b required 0/1", hresp, hready_out);
    end
    // Back-to-back: a second bad transfer during the second error cycle.
    drive(2'b10, 32'h0000_0100, 32'h0, 1'b0, 1'b1); tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    drive(2'b11, 32'hF000_0000, 32'h0, 1'b0, 1'b1); tick();
    n_tests++;
    if (hresp !== e_hresp || hready_out !== e_rdy) begin
      n_fail++;
      $display("FAIL err_back_to_back: hresp=%b hready_out=%b required %b/%b", hresp, hready_out, e_hresp, e_rdy);
    end
    // Second cycle held by apb_ready low.
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    @(negedge hclk); apb_ready = 1'b0; #1;
    n_tests++;
    if (hresp !== e_hresp || hready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL err2_apb_wait: hresp=%b hready_out=%b required %b/0", hresp, hready_out, e_hresp);
    end
    tick();
    n_tests++;
    if (hresp !== e_hresp || hready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL err2_hold: hresp=%b hready_out=%b required %b/0", hresp, hready_out, e_hresp);
    end
    @(negedge hclk); apb_ready = 1'b1; #1;
    n_tests++;
    if (hresp !== e_hresp || hready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL err2_release: hresp=%b hready_out=%b required %b/1", hresp, hready_out, e_hresp);
    end
    tick();
    n_tests++;
    if (hresp !== 1'b0 || hready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL err_done: hresp=%b hready_out=%b required 0/1", hresp, hready_out);
    end
    m_phase = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: a = BASE + (($urandom % (NSLV << SZL)) & 32'hFFFF_FFFC);
        1: a = BASE - 32'(4 * $urandom_range(1, 4));
        2: a = 32'h8C00_0000 + 32'(4 * $urandom_range(0, 3));
        3: a = $urandom;
        default: a = BASE + 32'($urandom_range(1, NSLV)) * (32'd1 << SZL) - 32'd4;
      endcase
      drive(2'($urandom_range(0, 3)), a, $urandom, 1'($urandom), ($urandom_range(0, 3) != 0));
      n_tests++;
      if (valid !== ref_valid(hready_in, htrans, haddr) || temp_sel !== ref_sel(haddr) ||
          hr_data !== pr_data) begin
        n_fail++;
        $display("FAIL rand_comb[%0d] haddr=%h htrans=%b rdy=%b: valid=%b temp_sel=%b hr_data=%h required %b/%b/%h",
                 n, haddr, htrans, hready_in, valid, temp_sel, hr_data,
                 ref_valid(hready_in, htrans, haddr), ref_sel(haddr), pr_data);
      end
      n_tests++;
      if (hresp !== (m_phase != 0) || hready_out !== (m_phase != 1)) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: hresp=%b hready_out=%b required %b/%b",
                 n, hresp, hready_out, (m_phase != 0), (m_phase != 1));
      end
      tick();
      for (int k = 0; k < PD; k++) begin
        n_tests++;
        if (haddr_p[k*ADDR_W +: ADDR_W] !== m_addr[k] || hwdata_p[k*DATA_W +: DATA_W] !== m_data[k] ||
            hwrite_p[k] !== m_wr[k]) begin
          n_fail++;
          $display("FAIL rand_stage%0d[%0d]: addr=%h data=%h wr=%b required %h/%h/%b",
                   k, n, haddr_p[k*ADDR_W +: ADDR_W], hwdata_p[k*DATA_W +: DATA_W], hwrite_p[k],
                   m_addr[k], m_data[k], m_wr[k]);
        end
      end
      n_tests++;
      if (sel_reg !== m_sel) begin
        n_fail++;
        $display("FAIL rand_sel_reg[%0d]: sel_reg=%b required %b", n, sel_reg, m_sel);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_write();
    test_stall();
    test_boundary();
    test_seq_outside();
    test_error_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
